// File: rtl/uart_pkg.sv
// Shared UART definitions: the byte width and the RX capture-state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        RXF_IDLE = 2'd0,
        RXF_CLR  = 2'd1,
        RXF_WAIT = 2'd2
    } rxf_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Register-array dual-port RAM: one synchronous write port, one asynchronous read port.
// Latency: a write lands on the clock edge; the read is combinational from the address.
// Backpressure: none; the caller owns all occupancy bookkeeping.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = UART_BYTE_W
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    // Contents are intentionally not reset; occupancy tracking masks stale entries.
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures flagged receiver bytes into a FWFT FIFO for the CPU.
// Latency: byte sampled in cycle N is visible on rd_data/count in N+1 with rx_rdy_clr in N+1.
// Backpressure: when full the byte is left unacknowledged in the receiver (or dropped and flagged with UART_RX_FIFO_OVERRUN_EN).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_rdy,
    input  logic [UART_BYTE_W-1:0] rx_data,
    output logic                   rx_rdy_clr,
    input  logic                   rd_en,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic                   empty,
    output logic                   full,
`ifdef UART_RX_FIFO_OVERRUN_EN
    output logic                   overrun,
    input  logic                   ovr_clr,
`endif
    output logic [DEPTH_LOG2:0]    count
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    rxf_state_e             state_q;
    rxf_state_e             state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q;
    logic [DEPTH_LOG2:0]    count_q;
    logic                   wr_go;
    logic                   pop_go;
    logic [UART_BYTE_W-1:0] ram_rd_data;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic                   drop_go;
    logic                   overrun_q;
`endif

    // Flags decode from the occupancy register only, so no input reaches them combinationally.
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_FULL);
    assign count      = count_q;
    assign rx_rdy_clr = (state_q == RXF_CLR);
    assign pop_go     = rd_en && !empty;
    assign rd_data    = empty ? '0 : ram_rd_data;

    // Capture decision and next state; full is judged before any same-cycle pop.
    always_comb begin
        state_d = state_q;
        wr_go   = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
        drop_go = 1'b0;
`endif
        case (state_q)
            RXF_IDLE: begin
                if (rx_rdy) begin
                    if (!full) begin
                        wr_go   = 1'b1;
                        state_d = RXF_CLR;
                    end
`ifdef UART_RX_FIFO_OVERRUN_EN
                    else begin
                        drop_go = 1'b1;
                        state_d = RXF_CLR;
                    end
`endif
                end
            end
            RXF_CLR:  state_d = RXF_WAIT;
            RXF_WAIT: if (!rx_rdy) state_d = RXF_IDLE;
            default:  state_d = RXF_IDLE;
        endcase
    end

    // Capture state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RXF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers wrap naturally; count holds on a simultaneous write and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_go)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_go) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({wr_go, pop_go})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    // Sticky dropped-byte flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (drop_go) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
`endif

    uart_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (UART_BYTE_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_go),
        .wr_addr (wr_ptr_q),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

endmodule
